pipe_hazard_ctrl: RTL and testbench

//  Central sequencer for the 5-stage miniRV pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_hazard_ctrl_pkg.sv | 34 +++
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the miniRV hazard controller: forwarding selects, FSM states, register match.
// Pure declarations; no timing or flow control of its own.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_t;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    // x0 is hardwired zero, so a write to it must never be forwarded.
    function automatic logic reg_match(input logic             rd_en,
                                       input logic [REG_W-1:0] rs,
                                       input logic             we,
                                       input logic [REG_W-1:0] wr);
        return rd_en && we && (wr == rs) && (rs != '0);
    endfunction

    function automatic fwd_sel_t fwd_pick(input logic ex, input logic mem, input logic wb);
        if (ex)  return FWD_EX;
        if (mem) return FWD_MEM;
        if (wb)  return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// RAW detection at ID: operand forwarding selects (EX > MEM > WB) and load-use detect.
// Purely combinational, zero latency; no flow control.
module pipe_hazard_ctrl_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs1_i,
    input  logic [REG_W-1:0] rs2_i,
    input  logic             rs1_use_i,
    input  logic             rs2_use_i,
    input  logic [REG_W-1:0] wr_ex_i,
    input  logic             we_ex_i,
    input  logic             is_load_ex_i,
    input  logic [REG_W-1:0] wr_mem_i,
    input  logic             we_mem_i,
    input  logic [REG_W-1:0] wr_wb_i,
    input  logic             we_wb_i,
    output fwd_sel_t         fwd_rs1_o,
    output fwd_sel_t         fwd_rs2_o,
    output logic             load_use_o
);

    logic m1_ex, m1_mem, m1_wb;
    logic m2_ex, m2_mem, m2_wb;

    always_comb begin
        m1_ex  = reg_match(rs1_use_i, rs1_i, we_ex_i,  wr_ex_i);
        m1_mem = reg_match(rs1_use_i, rs1_i, we_mem_i, wr_mem_i);
        m1_wb  = reg_match(rs1_use_i, rs1_i, we_wb_i,  wr_wb_i);
        m2_ex  = reg_match(rs2_use_i, rs2_i, we_ex_i,  wr_ex_i);
        m2_mem = reg_match(rs2_use_i, rs2_i, we_mem_i, wr_mem_i);
        m2_wb  = reg_match(rs2_use_i, rs2_i, we_wb_i,  wr_wb_i);

        fwd_rs1_o  = fwd_pick(m1_ex, m1_mem, m1_wb);
        fwd_rs2_o  = fwd_pick(m2_ex, m2_mem, m2_wb);
        // Load data only exists after MEM, so an EX-stage match on a load cannot forward.
        load_use_o = is_load_ex_i && (m1_ex || m2_ex);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: forwarding, load-use bubble, branch flush, data-bus freeze, perf counters.
// Controls are combinational from state+inputs and act at the next edge; a bus wait freezes every stage.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 255,
    parameter int WAIT_W   = 8
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic [REG_W-1:0]  rs1_ID_i,
    input  logic [REG_W-1:0]  rs2_ID_i,
    input  logic              rs1_use_i,
    input  logic              rs2_use_i,
    input  logic [REG_W-1:0]  wR_EX_i,
    input  logic              rf_we_EX_i,
    input  logic              is_load_EX_i,
    input  logic [REG_W-1:0]  wR_MEM_i,
    input  logic              rf_we_MEM_i,
    input  logic [REG_W-1:0]  wR_WB_i,
    input  logic              rf_we_WB_i,
    input  logic              br_taken_EX_i,
    input  logic              dmem_req_MEM_i,
    input  logic              dmem_ack_i,
    output logic [1:0]        fwd_rs1_o,
    output logic [1:0]        fwd_rs2_o,
    output logic              pc_hold_o,
    output logic              ifid_hold_o,
    output logic              ifid_flush_o,
    output logic              idex_hold_o,
    output logic              idex_flush_o,
    output logic              exmem_hold_o,
    output logic              memwb_bubble_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic              bus_timeout_o
);

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

    fwd_sel_t fwd1, fwd2;
    logic     load_use;

    pipe_hazard_ctrl_fwd_unit u_fwd (
        .rs1_i        (rs1_ID_i),
        .rs2_i        (rs2_ID_i),
        .rs1_use_i    (rs1_use_i),
        .rs2_use_i    (rs2_use_i),
        .wr_ex_i      (wR_EX_i),
        .we_ex_i      (rf_we_EX_i),
        .is_load_ex_i (is_load_EX_i),
        .wr_mem_i     (wR_MEM_i),
        .we_mem_i     (rf_we_MEM_i),
        .wr_wb_i      (wR_WB_i),
        .we_wb_i      (rf_we_WB_i),
        .fwd_rs1_o    (fwd1),
        .fwd_rs2_o    (fwd2),
        .load_use_o   (load_use)
    );

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              timeout_q, timeout_d;
    logic              bus_wait;
    logic              pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_bubble;

    always_comb begin
        bus_wait     = !dmem_ack_i && ((state_q == ST_MEM_WAIT) || dmem_req_MEM_i);
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        ifid_flush   = 1'b0;
        idex_hold    = 1'b0;
        idex_flush   = 1'b0;
        exmem_hold   = 1'b0;
        memwb_bubble = 1'b0;

        // A taken branch seen during a wait stays parked in EX and is flushed in the ack cycle.
        if (bus_wait) begin
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_hold   = 1'b1;
            memwb_bubble = 1'b1;
        end else if (br_taken_EX_i) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_flush = 1'b1;
        end

        state_d = bus_wait ? ST_MEM_WAIT : ST_RUN;
        if (!bus_wait)
            wait_cnt_d = '0;
        else if (state_q == ST_RUN)
            wait_cnt_d = WAIT_ONE;
        else if (wait_cnt_q != '1)
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
        else
            wait_cnt_d = wait_cnt_q;

        timeout_d   = timeout_q || (bus_wait && (wait_cnt_d == WAIT_LIM));
        stall_cnt_d = (pc_hold && (stall_cnt_q != '1))    ? stall_cnt_q + CNT_ONE : stall_cnt_q;
        flush_cnt_d = (ifid_flush && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_ONE : flush_cnt_q;
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign fwd_rs1_o      = fwd1;
    assign fwd_rs2_o      = fwd2;
    assign pc_hold_o      = pc_hold;
    assign ifid_hold_o    = ifid_hold;
    assign ifid_flush_o   = ifid_flush;
    assign idex_hold_o    = idex_hold;
    assign idex_flush_o   = idex_flush;
    assign exmem_hold_o   = exmem_hold;
    assign memwb_bubble_o = memwb_bubble;
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;
    assign bus_timeout_o  = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus a randomized run against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 4;
    localparam int WAIT_W   = 3;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_WAIT = 7'b1101011;
    localparam logic [6:0] C_BR   = 7'b0010100;
    localparam logic [6:0] C_LU   = 7'b1100100;

    logic             cpu_clk, cpu_rst;
    logic [4:0]       rs1_ID, rs2_ID, wR_EX, wR_MEM, wR_WB;
    logic             rs1_use, rs2_use, rf_we_EX, is_load_EX, rf_we_MEM, rf_we_WB;
    logic             br_taken_EX, dmem_req_MEM, dmem_ack;
    logic [1:0]       fwd_rs1, fwd_rs2;
    logic             pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_bubble;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             bus_timeout;
    logic [6:0]       ctl;

    assign ctl = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_bubble};

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX), .WAIT_W(WAIT_W)) dut (
        .cpu_clk        (cpu_clk),
        .cpu_rst        (cpu_rst),
        .rs1_ID_i       (rs1_ID),
        .rs2_ID_i       (rs2_ID),
        .rs1_use_i      (rs1_use),
        .rs2_use_i      (rs2_use),
        .wR_EX_i        (wR_EX),
        .rf_we_EX_i     (rf_we_EX),
        .is_load_EX_i   (is_load_EX),
        .wR_MEM_i       (wR_MEM),
        .rf_we_MEM_i    (rf_we_MEM),
        .wR_WB_i        (wR_WB),
        .rf_we_WB_i     (rf_we_WB),
        .br_taken_EX_i  (br_taken_EX),
        .dmem_req_MEM_i (dmem_req_MEM),
        .dmem_ack_i     (dmem_ack),
        .fwd_rs1_o      (fwd_rs1),
        .fwd_rs2_o      (fwd_rs2),
        .pc_hold_o      (pc_hold),
        .ifid_hold_o    (ifid_hold),
        .ifid_flush_o   (ifid_flush),
        .idex_hold_o    (idex_hold),
        .idex_flush_o   (idex_flush),
        .exmem_hold_o   (exmem_hold),
        .memwb_bubble_o (memwb_bubble),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt),
        .bus_timeout_o  (bus_timeout)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    int n_vec, n_err;

    // Reference model state: is a bus access outstanding, how long, and the perf tallies.
    bit         m_pending, m_timeout;
    int         m_waited, m_stall, m_flush;
    logic [1:0] e_fwd1, e_fwd2;
    logic [6:0] e_ctl;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic rd);
        if (!rd || rs == 5'd0) return 2'b00;
        if (rf_we_EX  && wR_EX  == rs) return 2'b01;
        if (rf_we_MEM && wR_MEM == rs) return 2'b10;
        if (rf_we_WB  && wR_WB  == rs) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat(input int v);
        return (v > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(v);
    endfunction

    task automatic model_reset();
        m_pending = 0; m_timeout = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_eval();
        bit lu, waiting;
        e_fwd1  = ref_fwd(rs1_ID, rs1_use);
        e_fwd2  = ref_fwd(rs2_ID, rs2_use);
        lu      = is_load_EX && rf_we_EX &&
                  ((rs1_use && rs1_ID != 0 && rs1_ID == wR_EX) || (rs2_use && rs2_ID != 0 && rs2_ID == wR_EX));
        waiting = !dmem_ack && (m_pending || dmem_req_MEM);
        if (waiting)          e_ctl = C_WAIT;
        else if (br_taken_EX) e_ctl = C_BR;
        else if (lu)          e_ctl = C_LU;
        else                  e_ctl = C_IDLE;
    endtask

    task automatic model_tick();
        m_stall += int'(e_ctl[6]);
        m_flush += int'(e_ctl[4]);
        if (!dmem_ack && (m_pending || dmem_req_MEM)) begin
            m_pending = 1;
            m_waited++;
            if (m_waited >= WAIT_MAX) m_timeout = 1;
        end else begin
            m_pending = 0;
            m_waited  = 0;
        end
    endtask

    task automatic idle();
        rs1_ID = 0; rs2_ID = 0; rs1_use = 0; rs2_use = 0;
        wR_EX = 0; rf_we_EX = 0; is_load_EX = 0;
        wR_MEM = 0; rf_we_MEM = 0; wR_WB = 0; rf_we_WB = 0;
        br_taken_EX = 0; dmem_req_MEM = 0; dmem_ack = 0;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        cpu_rst = 1'b1;
        tick();
        cpu_rst = 1'b0;
    endtask

    task automatic test_reset();
        cpu_rst = 1'b1;
        idle();
        settle();
        n_vec++; if (ctl !== C_IDLE) begin n_err++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_IDLE); end
        n_vec++; if ({fwd_rs1, fwd_rs2} !== 4'b0000) begin n_err++; $display("FAIL reset_fwd: got %b expected 0000", {fwd_rs1, fwd_rs2}); end
        n_vec++; if ({stall_cnt, flush_cnt, bus_timeout} !== '0) begin n_err++; $display("FAIL reset_regs: got %h/%h/%b expected 0/0/0", stall_cnt, flush_cnt, bus_timeout); end
        tick();
        cpu_rst = 1'b0;
    endtask

    task automatic test_fwd_ex();
        do_reset();
        rs1_ID = 5; rs1_use = 1; wR_EX = 5; rf_we_EX = 1;
        settle();
        n_vec++; if (fwd_rs1 !== 2'b01) begin n_err++; $display("FAIL fwd_ex: got %b expected 01", fwd_rs1); end
        n_vec++; if (ctl !== C_IDLE) begin n_err++; $display("FAIL fwd_ex_ctl: got %b expected %b", ctl, C_IDLE); end
        rs1_ID = 0; wR_EX = 0;
        settle();
        n_vec++; if (fwd_rs1 !== 2'b00) begin n_err++; $display("FAIL fwd_x0: got %b expected 00", fwd_rs1); end
    endtask

    task automatic test_fwd_priority();
        do_reset();
        rs2_ID = 7; rs2_use = 1;
        wR_EX = 7; rf_we_EX = 1; wR_MEM = 7; rf_we_MEM = 1; wR_WB = 7; rf_we_WB = 1;
        settle();
        n_vec++; if (fwd_rs2 !== 2'b01) begin n_err++; $display("FAIL fwd_prio_ex: got %b expected 01", fwd_rs2); end
        rf_we_EX = 0;
        settle();
        n_vec++; if (fwd_rs2 !== 2'b10) begin n_err++; $display("FAIL fwd_prio_mem: got %b expected 10", fwd_rs2); end
        rf_we_MEM = 0;
        settle();
        n_vec++; if (fwd_rs2 !== 2'b11) begin n_err++; $display("FAIL fwd_prio_wb: got %b expected 11", fwd_rs2); end
        rs2_use = 0;
        settle();
        n_vec++; if (fwd_rs2 !== 2'b00) begin n_err++; $display("FAIL fwd_no_use: got %b expected 00", fwd_rs2); end
    endtask

    task automatic test_load_use();
        do_reset();
        rs1_ID = 3; rs1_use = 1; wR_EX = 3; rf_we_EX = 1; is_load_EX = 1;
        settle();
        n_vec++; if (ctl !== C_LU) begin n_err++; $display("FAIL load_use_ctl: got %b expected %b", ctl, C_LU); end
        tick();
        rf_we_EX = 0; is_load_EX = 0; wR_EX = 0; wR_MEM = 3; rf_we_MEM = 1;
        settle();
        n_vec++; if (fwd_rs1 !== 2'b10) begin n_err++; $display("FAIL load_use_fwd: got %b expected 10", fwd_rs1); end
        n_vec++; if (ctl !== C_IDLE) begin n_err++; $display("FAIL load_use_once: got %b expected %b", ctl, C_IDLE); end
        n_vec++; if (stall_cnt !== CNT_W'(1)) begin n_err++; $display("FAIL load_use_stall_cnt: got %0d expected 1", stall_cnt); end
    endtask

    task automatic test_branch_vs_load_use();
        do_reset();
        rs1_ID = 3; rs1_use = 1; wR_EX = 3; rf_we_EX = 1; is_load_EX = 1; br_taken_EX = 1;
        settle();
        n_vec++; if (ctl !== C_BR) begin n_err++; $display("FAIL br_over_lu: got %b expected %b", ctl, C_BR); end
        tick();
        idle();
        settle();
        n_vec++; if (flush_cnt !== CNT_W'(1)) begin n_err++; $display("FAIL br_flush_cnt: got %0d expected 1", flush_cnt); end
        n_vec++; if (stall_cnt !== CNT_W'(0)) begin n_err++; $display("FAIL br_stall_cnt: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_bus_wait();
        do_reset();
        dmem_req_MEM = 1;
        for (int i = 1; i <= 3; i++) begin
            br_taken_EX = (i >= 2);
            settle();
            n_vec++; if (ctl !== C_WAIT) begin n_err++; $display("FAIL bus_wait_c%0d: got %b expected %b", i, ctl, C_WAIT); end
            tick();
        end
        dmem_ack = 1;
        settle();
        n_vec++; if (ctl !== C_BR) begin n_err++; $display("FAIL bus_ack_branch: got %b expected %b", ctl, C_BR); end
        tick();
        idle();
        settle();
        n_vec++; if (ctl !== C_IDLE) begin n_err++; $display("FAIL bus_back_to_run: got %b expected %b", ctl, C_IDLE); end
        n_vec++; if (stall_cnt !== CNT_W'(3)) begin n_err++; $display("FAIL bus_stall_cnt: got %0d expected 3", stall_cnt); end
        n_vec++; if (flush_cnt !== CNT_W'(1)) begin n_err++; $display("FAIL bus_flush_cnt: got %0d expected 1", flush_cnt); end
    endtask

    task automatic test_timeout();
        do_reset();
        dmem_req_MEM = 1;
        for (int i = 1; i <= WAIT_MAX; i++) begin
            settle();
            n_vec++; if (bus_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_early_c%0d: got %b expected 0", i, bus_timeout); end
            tick();
        end
        settle();
        n_vec++; if (bus_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_set: got %b expected 1", bus_timeout); end
        tick(); tick();
        n_vec++; if (bus_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: got %b expected 1", bus_timeout); end
        dmem_req_MEM = 0;
        #1 cpu_rst = 1'b1;
        #1;
        n_vec++; if (bus_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_rst: got %b expected 0", bus_timeout); end
        n_vec++; if (ctl !== C_IDLE) begin n_err++; $display("FAIL rst_mid_wait_run: got %b expected %b", ctl, C_IDLE); end
        tick();
        cpu_rst = 1'b0;
    endtask

    task automatic test_counter_sat();
        do_reset();
        br_taken_EX = 1;
        for (int i = 0; i < CNT_MAX + 5; i++) tick();
        idle();
        settle();
        n_vec++; if (flush_cnt !== CNT_W'(CNT_MAX)) begin n_err++; $display("FAIL flush_cnt_sat: got %0d expected %0d", flush_cnt, CNT_MAX); end
    endtask

    task automatic test_random();
        do_reset();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            rs1_ID = 5'($urandom_range(0, 3)); rs2_ID = 5'($urandom_range(0, 3));
            wR_EX  = 5'($urandom_range(0, 3)); wR_MEM = 5'($urandom_range(0, 3)); wR_WB = 5'($urandom_range(0, 3));
            rs1_use = 1'($urandom_range(0, 1)); rs2_use = 1'($urandom_range(0, 1));
            rf_we_EX = 1'($urandom_range(0, 1)); rf_we_MEM = 1'($urandom_range(0, 1)); rf_we_WB = 1'($urandom_range(0, 1));
            is_load_EX   = 1'($urandom_range(0, 1));
            br_taken_EX  = ($urandom_range(0, 7) == 0);
            dmem_req_MEM = ($urandom_range(0, 3) == 0);
            dmem_ack     = (c % 400 >= 300) ? 1'b0 : 1'($urandom_range(0, 1));
            settle();
            model_eval();
            n_vec++; if (fwd_rs1 !== e_fwd1) begin n_err++; $display("FAIL rnd_fwd1 c%0d: got %b expected %b", c, fwd_rs1, e_fwd1); end
            n_vec++; if (fwd_rs2 !== e_fwd2) begin n_err++; $display("FAIL rnd_fwd2 c%0d: got %b expected %b", c, fwd_rs2, e_fwd2); end
            n_vec++; if (ctl !== e_ctl) begin n_err++; $display("FAIL rnd_ctl c%0d: got %b expected %b", c, ctl, e_ctl); end
            n_vec++; if (stall_cnt !== sat(m_stall)) begin n_err++; $display("FAIL rnd_stall c%0d: got %0d expected %0d", c, stall_cnt, sat(m_stall)); end
            n_vec++; if (flush_cnt !== sat(m_flush)) begin n_err++; $display("FAIL rnd_flush c%0d: got %0d expected %0d", c, flush_cnt, sat(m_flush)); end
            n_vec++; if (bus_timeout !== m_timeout) begin n_err++; $display("FAIL rnd_timeout c%0d: got %b expected %b", c, bus_timeout, m_timeout); end
            model_tick();
            tick();
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cpu_rst = 1'b1;
        idle();
        #1;
        test_reset();
        test_fwd_ex();
        test_fwd_priority();
        test_load_use();
        test_branch_vs_load_use();
        test_bus_wait();
        test_timeout();
        test_counter_sat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
